// File: rtl/pll_div_clk_pkg.sv
// Shared defaults and the half-period calculation for the emulated PLL divider.
package pll_div_clk_pkg;

   localparam int DEF_CLK_FREQ_HZ = 12_000_000;
   localparam int DEF_OUT_FREQ_HZ = 1;
   localparam int DEF_LOCK_CYCLES = 16;

   // Number of input clocks per output half-period, truncated.
   function automatic int calc_half(input int clk_hz, input int out_hz);
      return clk_hz / (2 * out_hz);
   endfunction

endpackage

// File: rtl/pll_lock_timer.sv
// Emulated PLL lock: counts rising edges after reset release and asserts locked
// once LOCK_CYCLES edges have elapsed, holding it until the next reset.
module pll_lock_timer
   import pll_div_clk_pkg::*;
#(
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic clk,
   input  logic rst,
   output logic locked
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LAST = LW'(LOCK_CYCLES);

   logic [LW-1:0] lock_cnt;

   // Saturating count; locked rises on the same edge the count reaches LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (lock_cnt != LAST) begin
         lock_cnt <= lock_cnt + LW'(1);
         if (lock_cnt == LAST - LW'(1)) begin
            locked <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pll_div_clk.sv
// Divides clk down to a registered 50%-duty square wave at OUT_FREQ_HZ, gated by
// an emulated PLL lock, with a one-cycle tick on each rising output edge.
module pll_div_clk
   import pll_div_clk_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int OUT_FREQ_HZ = DEF_OUT_FREQ_HZ,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic clk,
   input  logic rst,
   output logic locked,
   output logic clk_1hz,
   output logic tick_1hz
);

   localparam int HALF  = calc_half(CLK_FREQ_HZ, OUT_FREQ_HZ);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   if (HALF < 1 || LOCK_CYCLES < 1) begin : g_bad_params
      $error("pll_div_clk: HALF and LOCK_CYCLES must both be at least 1");
   end

   logic [CNT_W-1:0] div_cnt;

   pll_lock_timer #(
      .LOCK_CYCLES(LOCK_CYCLES)
   ) u_lock (
      .clk   (clk),
      .rst   (rst),
      .locked(locked)
   );

   // Divider only advances on edges where locked was already high, so the first
   // output rise lands HALF edges after locked rises.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         clk_1hz  <= 1'b0;
         tick_1hz <= 1'b0;
      end else if (locked) begin
         tick_1hz <= 1'b0;
         if (div_cnt == LAST) begin
            div_cnt  <= '0;
            clk_1hz  <= ~clk_1hz;
            tick_1hz <= ~clk_1hz;
         end else begin
            div_cnt <= div_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pll_div_clk.sv
// Scoreboard bench for pll_div_clk with a small divide ratio (HALF=10, lock=4).
module tb_pll_div_clk;

   localparam int CLK_HZ = 20;
   localparam int OUT_HZ = 1;
   localparam int LOCKC  = 4;
   localparam int HALFV  = CLK_HZ / (2 * OUT_HZ);

   typedef struct packed {
      logic locked;
      logic clk_1hz;
      logic tick_1hz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic locked, clk_1hz, tick_1hz;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   run_edges = 0;   // rising edges with rst low since the last reset edge

   pll_div_clk #(
      .CLK_FREQ_HZ(CLK_HZ),
      .OUT_FREQ_HZ(OUT_HZ),
      .LOCK_CYCLES(LOCKC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .locked  (locked),
      .clk_1hz (clk_1hz),
      .tick_1hz(tick_1hz)
   );

   always #5 clk = ~clk;

   // Expected outputs after an edge, from elapsed-time arithmetic alone.
   function automatic exp_t model(input int n);
      exp_t e;
      int   t;
      e = '0;
      if (n >= LOCKC) begin
         t = n - LOCKC;
         e.locked   = 1'b1;
         e.clk_1hz  = ((t / HALFV) % 2) == 1;
         e.tick_1hz = (t >= HALFV) && (t % (2 * HALFV) == HALFV);
      end
      return e;
   endfunction

   task automatic drive(input logic r);
      @(negedge clk);
      rst = r;
      if (r) run_edges = 0;
      else   run_edges++;
      exp_q.push_back(model(run_edges));
   endtask

   task automatic check(input string name, input logic got, input logic want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("locked",   locked,   e.locked);
            check("clk_1hz",  clk_1hz,  e.clk_1hz);
            check("tick_1hz", tick_1hz, e.tick_1hz);
         end
      end
   end

   initial begin : stimulus
      int guard;
      // Lock timing and first toggle: 3 reset edges, then a long free run.
      for (int i = 0; i < 3; i++) drive(1'b1);
      for (int i = 0; i < 110; i++) drive(1'b0);

      // Mid-period reset with the divider at 5 and clk_1hz high.
      guard = 0;
      while (!((run_edges >= LOCKC) && ((run_edges - LOCKC) % (2 * HALFV) == HALFV + 5))
             && guard < 100) begin
         drive(1'b0);
         guard++;
      end
      tests++;
      if (guard >= 100) begin
         fails++;
         $display("FAIL midreset_setup: got %0d edges waited, expected < 100", guard);
      end
      drive(1'b1);
      for (int i = 0; i < 40; i++) drive(1'b0);

      // Randomized reset pulses of random length between random run lengths.
      for (int k = 0; k < 12; k++) begin
         int len = $urandom_range(60, 1);
         int rl  = $urandom_range(3, 1);
         for (int i = 0; i < len; i++) drive(1'b0);
         for (int i = 0; i < rl; i++) drive(1'b1);
      end
      for (int i = 0; i < 50; i++) drive(1'b0);

      repeat (3) @(posedge clk);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pll_div_clk.md
PLL_DIV_CLK -- requirements
Module: pll_div_clk

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 12_000_000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter OUT_FREQ_HZ, default 1, meaning output square-wave frequency in Hz.
REQ-003 The block SHALL have parameter LOCK_CYCLES, default 16, meaning clk cycles after reset before locked asserts.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port locked, output, 1 bit, high when the emulated PLL is stable.
REQ-007 The block SHALL have port clk_1hz, output, 1 bit, registered 50%-duty square wave at OUT_FREQ_HZ.
REQ-008 The block SHALL have port tick_1hz, output, 1 bit, one-cycle pulse coincident with each clk_1hz 0->1 transition.

Function
REQ-009 HALF SHALL equal CLK_FREQ_HZ / (2*OUT_FREQ_HZ), truncated; the default is 6_000_000.
REQ-010 Elaboration SHALL fail if HALF < 1 or LOCK_CYCLES < 1.
REQ-011 The divide counter width SHALL be $clog2(HALF), minimum 1 bit.
REQ-012 The lock counter SHALL increment once per rising edge with rst low, saturating at LOCK_CYCLES.
REQ-013 locked SHALL go high on the LOCK_CYCLES-th rising edge after rst is sampled low, and remain high until rst.
REQ-014 While locked is low, the divide counter, clk_1hz and tick_1hz SHALL hold their reset values.
REQ-015 On each edge where locked is already high, the divide counter SHALL count 0..HALF-1.
REQ-016 At HALF-1 the divide counter SHALL wrap to 0 and clk_1hz SHALL toggle on that same edge.
REQ-017 clk_1hz SHALL therefore first rise HALF edges after locked rises, and have period 2*HALF cycles.
REQ-018 tick_1hz SHALL be registered and high for exactly the one cycle in which clk_1hz has just become 1.
REQ-019 tick_1hz SHALL be low at all other times, including the cycle in which clk_1hz falls.
REQ-020 clk_1hz SHALL be a data signal driven from a flip-flop; the block SHALL NOT use clock gating or combinational clock outputs.

Reset
REQ-021 When rst is high at a rising edge, the following SHALL hold on that edge: locked=0, lock counter=0, divide counter=0, clk_1hz=0, tick_1hz=0.
REQ-022 Reset asserted mid-operation, including mid-period, SHALL abort the current period.
REQ-023 After such a reset, the full lock sequence of REQ-013 SHALL repeat.
REQ-024 rst SHALL take priority over all counting.

Structure
REQ-025 A shared package pll_div_clk_pkg SHALL hold the default constants DEF_CLK_FREQ_HZ, DEF_OUT_FREQ_HZ and DEF_LOCK_CYCLES, and a function computing HALF.
REQ-026 One sub-module, pll_lock_timer, SHALL contain the lock counter and locked register.
REQ-027 The divider logic SHALL live in pll_div_clk.

Verification
All scenarios use CLK_FREQ_HZ=20, OUT_FREQ_HZ=1, LOCK_CYCLES=4, so HALF=10.
REQ-028 Lock timing: hold rst high for 3 edges, then release -> locked rises on the 4th edge after release; clk_1hz/tick_1hz stay 0 throughout.
REQ-029 First toggle: after locked=1, count edges -> clk_1hz rises on the 10th edge; tick_1hz is high for exactly that one cycle.
REQ-030 Steady state: run 100 cycles -> clk_1hz is high 10 and low 10 cycles repeatedly; tick_1hz pulses every 20 cycles; no tick on falling edges.
REQ-031 Mid-period reset: assert rst for 1 edge when the counter is 5 with clk_1hz=1 -> all outputs become 0 on that edge; the relock takes 4 edges; the next rise is 10 edges later.
REQ-032 Default parameters: run 12_000_016+ cycles -> the first clk_1hz rise occurs 6_000_000 edges after locked, and tick_1hz spacing is 12_000_000 cycles.
REQ-033 Illegal parameters: instantiate with CLK_FREQ_HZ=1, OUT_FREQ_HZ=1 -> elaboration error.
